fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  IF stage plus IF/ID pipeline register of the 5-stage RV32I core, directly upstream of decode.
//  Holds PCF and issues one-outstanding fetches to instruction memory over a req/gnt/rvalid handshake.
//  Buffers returned words in a small queue and presents InstrD/PCD/PCPlus4D to decode.
//  Obeys StallF/StallD/FlushD from the hazard unit and redirects on PCSrcE/PCTargetE.
// PARAMETERS
//  XLEN       32            data/address width
//  RESET_PC   32'h0000_0000 PCF value after reset
//  Q_DEPTH    2             instruction queue entries (power of 2, >=2)
// PORTS
//  clk          in   1     clock
//  rst          in   1     synchronous, active-high reset
//  StallF       in   1     hazard unit: hold PCF, issue no new request
//  StallD       in   1     hazard unit: hold IF/ID register
//  FlushD       in   1     hazard unit: IF/ID register -> bubble
//  PCSrcE       in   1     taken branch/jump resolved in EX
//  PCTargetE    in   XLEN  redirect target
//  imem_req     out  1     fetch request valid
//  imem_addr    out  XLEN  fetch address (word aligned)
//  imem_gnt     in   1     request accepted this cycle
//  imem_rvalid  in   1     response valid (>=1 cycle after gnt)
//  imem_rdata   in   32    response instruction word
//  InstrD       out  32    instruction to decode
//  PCD          out  XLEN  PC of InstrD
//  PCPlus4D     out  XLEN  PCD+4
//  ValidD       out  1     InstrD is a real instruction (0 = bubble)
// BEHAVIOUR
//  Reset: PCF=RESET_PC, queue empty, FSM=IDLE, imem_req=0, InstrD=32'h0000_0013 (NOP), PCD=0, PCPlus4D=0, ValidD=0.
//  FSM states: IDLE (none outstanding), BUSY (one accepted, awaiting rvalid), DISCARD (outstanding response to drop).
//   IDLE: imem_req=1, imem_addr=PCF when !StallF && queue has space incl. slot reserved for response; on gnt -> BUSY, tag=PCF, PCF+=4.
//   BUSY: imem_req=0; on rvalid push {tag,rdata} -> IDLE (may re-request next cycle, not same cycle).
//   DISCARD: imem_req=0; on rvalid drop data -> IDLE.
//  Redirect (PCSrcE=1): PCF<=PCTargetE, queue cleared, BUSY->DISCARD (DISCARD stays), any gnt that same cycle is ignored
//   (imem_req forced 0 while PCSrcE=1). Redirect beats StallF. Hazard unit asserts FlushD alongside.
//  IF/ID register update priority: FlushD > StallD > load.
//   FlushD: InstrD=NOP, ValidD=0 (PCD/PCPlus4D don't-care, hold).
//   StallD: hold all; no pop.
//   else queue non-empty: pop head -> InstrD/PCD, PCPlus4D=PCD+4, ValidD=1; empty: NOP, ValidD=0.
//  Queue push and pop same cycle allowed when full or empty (push into freed slot / no bypass: a pushed word is
//   visible to decode no earlier than the next cycle). Never overflows: requests throttled by reserve rule.
//  rvalid in IDLE is a protocol error: ignored (assert in sim).
//  Addresses wrap modulo 2^XLEN; PCTargetE[1:0] ignored (forced 0).
//  rst mid-transaction: FSM->IDLE immediately; the env must not deliver a stale rvalid after reset.
// CONFIGURATION
//  FETCH_PERF_EN defined: extra outputs perf_bubble_cnt[31:0] (cycles ValidD load wrote bubble due to empty queue,
//   excl. FlushD/StallD) and perf_redirect_cnt[31:0] (cycles PCSrcE=1); both reset to 0, wrap at 2^32.
//  Undefined: ports and counters absent, behaviour otherwise identical.
// STRUCTURE
//  riscv_pkg: NOP_INSTR=32'h0000_0013, fetch_state_t enum {IDLE,BUSY,DISCARD}, fetch_entry_t struct {pc,instr}.
//  Sub-module fetch_queue: synchronous FIFO of fetch_entry_t, Q_DEPTH, push/pop/clear, count, full/empty.
//  Top holds PCF, FSM, request logic, IF/ID register.
// TESTING
//  1 Reset, gnt=1, rvalid 1 cycle after gnt -> addrs 0,4,8,... ; ValidD=1 with PCD=0 first, then 4,8; PCPlus4D=PCD+4.
//  2 StallF=StallD=1 for 3 cycles mid-stream -> no new gnt, InstrD/PCD held; resumes with next sequential PC.
//  3 PCSrcE=1, PCTargetE=0x100 while BUSY for PC 0x20 -> its rvalid dropped, next imem_addr=0x100, first valid PCD=0x100.
//  4 FlushD=1 with StallD=1 -> InstrD=0x00000013, ValidD=0 (flush wins).
//  5 rvalid latency 5 cycles, StallD=1 for 10 -> queue fills to Q_DEPTH, imem_req drops, no word lost or duplicated.
//  6 FETCH_PERF_EN: empty-queue bubbles during 5-cycle latency -> perf_bubble_cnt counts exactly those cycles.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared core types for the fetch stage (NOP encoding, fetch FSM states, queue entry)
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic [1:0] {IDLE, BUSY, DISCARD} fetch_state_t;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO of fetch_entry_t with clear; dout shows head (no push-to-pop bypass)
// ports: clk, rst, clear, push, pop, din, dout, count, full, empty
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  fetch_entry_t             din,
  output fetch_entry_t             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push && !clear && !rst) mem[wr_ptr] <= din;
  always_ff @(posedge clk)
    if (rst || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage + IF/ID register; one-outstanding imem fetch, response queue, redirect/stall/flush
// ports: clk, rst (sync, active-high); hazard StallF/StallD/FlushD; redirect PCSrcE/PCTargetE;
//        imem_req/addr/gnt/rvalid/rdata; decode InstrD/PCD/PCPlus4D/ValidD
// FETCH_PERF_EN adds perf_bubble_cnt (empty-queue bubbles) and perf_redirect_cnt (PCSrcE cycles)
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              Q_DEPTH  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_bubble_cnt,
  output logic [31:0]     perf_redirect_cnt
`endif
);
  fetch_state_t state_q, state_d;
  logic [XLEN-1:0] pcf, tag;
  logic fire, q_push, q_pop, q_full, q_empty;
  logic [$clog2(Q_DEPTH):0] q_count;
  fetch_entry_t q_in, q_head;
  // A request is only issued from IDLE, so a free queue slot is guaranteed for its response.
  assign imem_req = !rst && state_q == IDLE && !StallF && !PCSrcE && !q_full;
  assign imem_addr = pcf;
  assign fire = imem_req && imem_gnt;
  assign q_push = state_q == BUSY && imem_rvalid && !PCSrcE;
  assign q_pop = !FlushD && !StallD && !q_empty;
  assign q_in = '{pc: tag, instr: imem_rdata};
  fetch_queue #(.DEPTH(Q_DEPTH)) u_queue (
    .clk(clk),
    .rst(rst),
    .clear(PCSrcE),
    .push(q_push),
    .pop(q_pop),
    .din(q_in),
    .dout(q_head),
    .count(q_count),
    .full(q_full),
    .empty(q_empty)
  );
  always_comb begin
    state_d = state_q;
    state_d = state_q != IDLE && imem_rvalid ? IDLE
            : state_q == BUSY && PCSrcE      ? DISCARD
            : fire                           ? BUSY
            : state_q;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      pcf <= RESET_PC;
      tag <= '0;
    end else begin
      state_q <= state_d;
      if (PCSrcE) pcf <= {PCTargetE[XLEN-1:2], 2'b00};
      else if (fire) pcf <= pcf + XLEN'(4);
      if (fire) tag <= pcf;
    end
  always_ff @(posedge clk)
    if (rst) begin
      InstrD <= NOP_INSTR;
      PCD <= '0;
      PCPlus4D <= '0;
      ValidD <= 1'b0;
    end else if (FlushD) begin
      InstrD <= NOP_INSTR;
      ValidD <= 1'b0;
    end else if (!StallD) begin
      InstrD <= q_empty ? NOP_INSTR : q_head.instr;
      ValidD <= !q_empty;
      if (!q_empty) begin
        PCD <= q_head.pc;
        PCPlus4D <= q_head.pc + XLEN'(4);
      end
    end
  always_ff @(posedge clk)
    if (!rst) begin
      assert (!(state_q == IDLE && imem_rvalid));
      assert (q_count <= ($clog2(Q_DEPTH) + 1)'(Q_DEPTH));
    end
`ifdef FETCH_PERF_EN
  always_ff @(posedge clk)
    if (rst) begin
      perf_bubble_cnt <= '0;
      perf_redirect_cnt <= '0;
    end else begin
      if (!FlushD && !StallD && q_empty) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
      if (PCSrcE) perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
    end
`endif
endmodule
